// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multicycle MIPS-style control sequencer with memory-timeout and illegal-opcode trap; define MC_JAL_EN to enable JAL.
module mc_seq_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_rdy,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ireg_enab,
  output logic             pc_write,
  output logic             branch,
  output logic             branch_ne,
  output logic             reg_write,
  output logic             alu_srcA,
  output logic             zext,
  output logic [1:0]       pc_src,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_srcB,
  output logic [2:0]       alu_op,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [RET_W-1:0] retired
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_TO_REG, MEM_WRITE, EXECUTE,
    ALU_TO_REG, BRANCH, IMM_EXEC, IMM_TO_REG, JUMP, TRAP
`ifdef MC_JAL_EN
    , JAL_LINK
`endif
  } state_t;

  state_t      state, nxt;
  logic [15:0] wait_cnt;
  logic [1:0]  cause, nxt_cause;
  logic        mem_wait, timeout;

  assign mem_wait   = mem_req & ~mem_rdy;
  assign timeout    = mem_wait && (wait_cnt == WAIT_LAST);
  assign trap_cause = cause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      cause    <= 2'b00;
      retired  <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= mem_wait ? wait_cnt + 16'd1 : 16'd0;
      cause    <= nxt_cause;
      // only terminal states can enter FETCH from elsewhere, so this counts completions
      if (nxt == FETCH && state != FETCH) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt       = state;
    nxt_cause = cause;
    case (state)
      FETCH:     nxt = mem_rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_RTYPE:                 nxt = EXECUTE;
          OP_LW, OP_SW:             nxt = MEM_ADDR;
          OP_BEQ, OP_BNE:           nxt = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: nxt = IMM_EXEC;
          OP_J:                     nxt = JUMP;
`ifdef MC_JAL_EN
          OP_JAL:                   nxt = JAL_LINK;
`endif
          default: begin
            nxt       = TRAP;
            nxt_cause = 2'b01;
          end
        endcase
      end
      MEM_ADDR:  nxt = (op == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  nxt = mem_rdy ? MEM_TO_REG : MEM_READ;
      MEM_WRITE: nxt = mem_rdy ? FETCH : MEM_WRITE;
      EXECUTE:   nxt = ALU_TO_REG;
      IMM_EXEC:  nxt = IMM_TO_REG;
      TRAP:      nxt = TRAP;
      default:   nxt = FETCH;
    endcase
    if (timeout) begin
      nxt       = TRAP;
      nxt_cause = 2'b10;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ireg_enab  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    reg_write  = 1'b0;
    alu_srcA   = 1'b0;
    zext       = 1'b0;
    pc_src     = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_srcB   = 2'b00;
    alu_op     = ALU_ADD;
    trap       = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_srcB  = 2'b01;
        ireg_enab = mem_rdy;
        pc_write  = mem_rdy;
      end
      DECODE:   alu_srcB = 2'b11;
      MEM_ADDR: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
      end
      MEM_READ: begin
        i_or_d  = 1'b1;
        mem_req = 1'b1;
      end
      MEM_WRITE: begin
        i_or_d  = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      MEM_TO_REG: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
      end
      EXECUTE: begin
        alu_srcA = 1'b1;
        alu_op   = ALU_FUNCT;
      end
      ALU_TO_REG: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_srcA  = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        branch    = op == OP_BEQ;
        branch_ne = op == OP_BNE;
      end
      IMM_EXEC: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        alu_op   = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_ADD;
        zext     = (op == OP_ANDI) || (op == OP_ORI);
      end
      IMM_TO_REG: reg_write = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MC_JAL_EN
      JAL_LINK: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
`endif
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl: vector-table bench for mc_seq_ctrl with MEM_TIMEOUT=4, RET_W=2.
module tb_mc_seq_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_rdy;
  logic       mem_req, mem_we, i_or_d, ireg_enab, pc_write, branch, branch_ne, reg_write, alu_srcA, zext, trap;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_srcB, trap_cause, retired;
  logic [2:0] alu_op;
  logic [23:0] outs;
  int n_chk = 0;
  int n_fail = 0;

  mc_seq_ctrl #(.MEM_TIMEOUT(4), .RET_W(2)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ireg_enab(ireg_enab),
    .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne), .reg_write(reg_write),
    .alu_srcA(alu_srcA), .zext(zext), .pc_src(pc_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_srcB(alu_srcB), .alu_op(alu_op), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, i_or_d, ireg_enab, pc_write, branch, branch_ne, reg_write, alu_srcA, zext,
                 pc_src, reg_dst, mem_to_reg, alu_srcB, alu_op, trap, trap_cause};

  // {mreq,we,iod,ire,pcw,br,bne,rw,srcA,zext}, pc_src, reg_dst, mem_to_reg, alu_srcB, alu_op, trap, cause
  localparam logic [23:0] FE1  = {10'b1001100000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] FE0  = {10'b1000000000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] DEC  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] MA   = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] MR   = {10'b1010000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] MW   = {10'b1110000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] M2R  = {10'b0000000100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] EXE  = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0, 2'b00};
  localparam logic [23:0] A2R  = {10'b0000000100, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] BEQ  = {10'b0000010010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0, 2'b00};
  localparam logic [23:0] BNE  = {10'b0000001010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0, 2'b00};
  localparam logic [23:0] IADD = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] IAND = {10'b0000000011, 2'b00, 2'b00, 2'b00, 2'b10, 3'b011, 1'b0, 2'b00};
  localparam logic [23:0] IOR  = {10'b0000000011, 2'b00, 2'b00, 2'b00, 2'b10, 3'b100, 1'b0, 2'b00};
  localparam logic [23:0] I2R  = {10'b0000000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] JMP  = {10'b0000100000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] JAL  = {10'b0000100100, 2'b10, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0, 2'b00};
  localparam logic [23:0] TR1  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 2'b01};
  localparam logic [23:0] TR2  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 2'b10};

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, OBEQ = 6'b000100, OBNE = 6'b000101,
                         ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, OJ = 6'b000010, OJAL = 6'b000011,
                         BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [23:0] exp;
    logic [1:0]  ret;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic [5:0] o, input logic r, input logic [23:0] e, input logic [1:0] rt);
    vt.push_back('{o, r, e, rt});
  endfunction

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive on the falling edge, sample 1 ns later, then move on to the next falling edge
  task automatic apply(input string nm, input logic [5:0] o, input logic r, input logic [23:0] e, input logic [1:0] rt);
    op = o;
    mem_rdy = r;
    #1;
    chk({nm, " outs"}, outs, e);
    chk({nm, " retired"}, {22'd0, retired}, {22'd0, rt});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    op = RT;
    mem_rdy = 1'b0;
    add(LW, 1, FE1, 0);  add(LW, 1, DEC, 0); add(LW, 1, MA, 0);   add(LW, 1, MR, 0);  add(LW, 1, M2R, 0);
    add(SW, 1, FE1, 1);  add(SW, 1, DEC, 1); add(SW, 1, MA, 1);   add(SW, 0, MW, 1);  add(SW, 1, MW, 1);
    add(OBNE, 1, FE1, 2); add(OBNE, 1, DEC, 2); add(OBNE, 1, BNE, 2);
    add(OBEQ, 1, FE1, 3); add(OBEQ, 1, DEC, 3); add(OBEQ, 1, BEQ, 3);
    add(ORI, 1, FE1, 0); add(ORI, 1, DEC, 0); add(ORI, 1, IOR, 0); add(ORI, 1, I2R, 0);
    add(ANDI, 1, FE1, 1); add(ANDI, 1, DEC, 1); add(ANDI, 1, IAND, 1); add(ANDI, 1, I2R, 1);
    add(ADDI, 1, FE1, 2); add(ADDI, 1, DEC, 2); add(ADDI, 1, IADD, 2); add(ADDI, 1, I2R, 2);
    add(RT, 1, FE1, 3);  add(RT, 1, DEC, 3); add(RT, 1, EXE, 3);  add(RT, 1, A2R, 3);
    add(OJ, 1, FE1, 0);  add(OJ, 1, DEC, 0); add(OJ, 1, JMP, 0);
    add(RT, 0, FE0, 1);  add(RT, 0, FE0, 1); add(RT, 0, FE0, 1);  add(RT, 1, FE1, 1);
    add(RT, 1, DEC, 1);  add(RT, 1, EXE, 1); add(RT, 1, A2R, 1);
    add(BAD, 1, FE1, 2); add(BAD, 1, DEC, 2); add(BAD, 1, TR1, 2); add(RT, 1, TR1, 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    foreach (vt[i]) apply($sformatf("vec%0d", i), vt[i].op, vt[i].rdy, vt[i].exp, vt[i].ret);

    do_reset();
    apply("to_fetch", SW, 1, FE1, 0);
    apply("to_dec", SW, 1, DEC, 0);
    apply("to_ma", SW, 1, MA, 0);
    for (int i = 0; i < 4; i++) apply($sformatf("to_wait%0d", i), SW, 0, MW, 0);
    apply("to_trap", SW, 0, TR2, 0);
    apply("to_sticky", SW, 1, TR2, 0);
    do_reset();
    for (int i = 0; i < 3; i++) apply($sformatf("mid_wait%0d", i), RT, 0, FE0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) apply($sformatf("post_rst%0d", i), RT, 0, FE0, 0);

    for (int k = 0; k < 5; k++) begin
      apply($sformatf("rt%0d_fe", k), RT, 1, FE1, 2'(k));
      apply($sformatf("rt%0d_dec", k), RT, 1, DEC, 2'(k));
      apply($sformatf("rt%0d_exe", k), RT, 1, EXE, 2'(k));
      apply($sformatf("rt%0d_a2r", k), RT, 1, A2R, 2'(k));
    end
    apply("jal_fe", OJAL, 1, FE1, 1);
    apply("jal_dec", OJAL, 1, DEC, 1);
`ifdef MC_JAL_EN
    apply("jal_link", OJAL, 1, JAL, 1);
    apply("jal_done", RT, 1, FE1, 2);
`else
    apply("jal_trap", OJAL, 1, TR1, 1);
    apply("jal_sticky", RT, 1, TR1, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
